// File: rtl/kinase_valve_sequencer.sv
// Valve/pump step sequencer for the kinase-activity chip: settle, pump, optional flush.
// One command at a time; every pad drive is registered from the next-state view.
module kinase_valve_sequencer #(
  parameter int NUM_CTRL   = 13,
  parameter int NUM_SEL    = 4,
  parameter int NUM_PUMP   = 3,
  parameter int PUMP_PH    = 3,
  parameter int PUMP_DIV   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int FLUSH_CYC  = 16,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1,
  localparam int PA_W      = NUM_PUMP * PUMP_PH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [NUM_CTRL-1:0] cmd_ctrl,
  input  logic [SEL_W-1:0]    cmd_sel,
  input  logic [NUM_PUMP-1:0] cmd_pump,
  input  logic [CNT_W-1:0]    cmd_cycles,
  input  logic                cmd_flush,
  input  logic                abort,
  output logic [NUM_CTRL-1:0] ctrl_a,
  output logic [NUM_SEL-1:0]  ctrl_s,
  output logic [PA_W-1:0]     pump_a,
  output logic [NUM_CTRL-1:0] flush_ctrl,
  output logic [NUM_PUMP-1:0] flush_pump,
  output logic                busy,
  output logic                done,
  output logic                done_abort,
  output logic                done_err
);

  localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
  localparam int PH_W  = $clog2(PUMP_PH);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [PH_W-1:0]     ph_q, ph_d;

  logic [NUM_CTRL-1:0] ctrl_q, ctrl_d;
  logic [NUM_SEL-1:0]  sel_oh_q, sel_oh_d, sel_oh_in;
  logic [NUM_PUMP-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic                flush_q, flush_d;
  logic                abort_q, abort_d;
  logic                err_q, err_d;

  logic [NUM_CTRL-1:0] ctrl_a_q, ctrl_a_d;
  logic [NUM_SEL-1:0]  ctrl_s_q, ctrl_s_d;
  logic [PA_W-1:0]     pump_a_q, pump_a_d;
  logic [NUM_CTRL-1:0] flush_ctrl_q, flush_ctrl_d;
  logic [NUM_PUMP-1:0] flush_pump_q, flush_pump_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                done_abort_q, done_abort_d;
  logic                done_err_q, done_err_d;

  // An out-of-range selector decodes to no bit set, which doubles as the error flag.
  always_comb begin
    sel_oh_in = '0;
    for (int j = 0; j < NUM_SEL; j++) sel_oh_in[j] = (cmd_sel == SEL_W'(j));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    ph_d     = ph_q;
    ctrl_d   = ctrl_q;
    sel_oh_d = sel_oh_q;
    pmask_d  = pmask_q;
    cyc_d    = cyc_q;
    flush_d  = flush_q;
    abort_d  = abort_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ctrl_d   = cmd_ctrl;
          sel_oh_d = sel_oh_in;
          err_d    = ~|sel_oh_in;
          pmask_d  = cmd_pump;
          cyc_d    = cmd_cycles;
          flush_d  = cmd_flush;
          abort_d  = 1'b0;
          cnt_d    = CNT_W'(SETTLE_CYC - 1);
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          abort_d = 1'b1;
          cnt_d   = CNT_W'(FLUSH_CYC - 1);
          state_d = S_FLUSH;
        end else if (cnt_q == '0) begin
          if (cyc_q != '0) begin
            cnt_d   = cyc_q - CNT_W'(1);
            div_d   = '0;
            ph_d    = '0;
            state_d = S_RUN;
          end else if (flush_q) begin
            cnt_d   = CNT_W'(FLUSH_CYC - 1);
            state_d = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (abort) begin
          abort_d = 1'b1;
          cnt_d   = CNT_W'(FLUSH_CYC - 1);
          state_d = S_FLUSH;
        end else if (cnt_q == '0) begin
          if (flush_q) begin
            cnt_d   = CNT_W'(FLUSH_CYC - 1);
            state_d = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // One shared phase for all pumps, stepping every PUMP_DIV clocks.
          if (div_q == DIV_W'(PUMP_DIV - 1)) begin
            div_d = '0;
            ph_d  = (ph_q == PH_W'(PUMP_PH - 1)) ? '0 : ph_q + PH_W'(1);
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_a_d     = '0;
    ctrl_s_d     = '0;
    pump_a_d     = '0;
    flush_ctrl_d = '0;
    flush_pump_d = '0;
    done_d       = 1'b0;
    done_abort_d = 1'b0;
    done_err_d   = 1'b0;
    busy_d       = (state_d != S_IDLE);
    if (state_d == S_SETTLE || state_d == S_RUN) begin
      ctrl_a_d = ctrl_d;
      ctrl_s_d = sel_oh_d;
    end
    if (state_d == S_RUN) begin
      for (int i = 0; i < NUM_PUMP; i++)
        pump_a_d[i*PUMP_PH +: PUMP_PH] = pmask_d[i] ? (PUMP_PH'(1) << ph_d) : '0;
    end
    if (state_d == S_FLUSH) begin
      flush_ctrl_d = ctrl_d;
      flush_pump_d = pmask_d;
    end
    if (state_d == S_DONE) begin
      done_d       = 1'b1;
      done_abort_d = abort_d;
      done_err_d   = err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      ph_q         <= '0;
      ctrl_q       <= '0;
      sel_oh_q     <= '0;
      pmask_q      <= '0;
      cyc_q        <= '0;
      flush_q      <= 1'b0;
      abort_q      <= 1'b0;
      err_q        <= 1'b0;
      ctrl_a_q     <= '0;
      ctrl_s_q     <= '0;
      pump_a_q     <= '0;
      flush_ctrl_q <= '0;
      flush_pump_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_abort_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      ph_q         <= ph_d;
      ctrl_q       <= ctrl_d;
      sel_oh_q     <= sel_oh_d;
      pmask_q      <= pmask_d;
      cyc_q        <= cyc_d;
      flush_q      <= flush_d;
      abort_q      <= abort_d;
      err_q        <= err_d;
      ctrl_a_q     <= ctrl_a_d;
      ctrl_s_q     <= ctrl_s_d;
      pump_a_q     <= pump_a_d;
      flush_ctrl_q <= flush_ctrl_d;
      flush_pump_q <= flush_pump_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_abort_q <= done_abort_d;
      done_err_q   <= done_err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign ctrl_a     = ctrl_a_q;
  assign ctrl_s     = ctrl_s_q;
  assign pump_a     = pump_a_q;
  assign flush_ctrl = flush_ctrl_q;
  assign flush_pump = flush_pump_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_abort = done_abort_q;
  assign done_err   = done_err_q;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Bench for kinase_valve_sequencer: per-cycle expected trace built at acceptance,
// plus a done scoreboard (latency/abort) filled when stimulus is issued.
module tb_kinase_valve_sequencer;
  localparam int S = 8, F = 16, DIV = 4, PH = 3;

  logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_flush = 1'b0, abort = 1'b0;
  logic [12:0] cmd_ctrl = '0;
  logic [2:0]  cmd_sel = '0, cmd_pump = '0;
  logic [15:0] cmd_cycles = '0;

  logic        cmd_ready, busy, done, done_abort, done_err;
  logic [12:0] ctrl_a, flush_ctrl;
  logic [3:0]  ctrl_s;
  logic [8:0]  pump_a;
  logic [2:0]  flush_pump;

  logic        cmd_ready5, busy5, done5, done_abort5, done_err5;
  logic [12:0] ctrl_a5, flush_ctrl5;
  logic [4:0]  ctrl_s5;
  logic [8:0]  pump_a5;
  logic [2:0]  flush_pump5;

  always #5 clk = ~clk;

  kinase_valve_sequencer u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl(cmd_ctrl), .cmd_sel(cmd_sel[1:0]), .cmd_pump(cmd_pump),
    .cmd_cycles(cmd_cycles), .cmd_flush(cmd_flush), .abort(abort),
    .ctrl_a(ctrl_a), .ctrl_s(ctrl_s), .pump_a(pump_a), .flush_ctrl(flush_ctrl),
    .flush_pump(flush_pump), .busy(busy), .done(done), .done_abort(done_abort),
    .done_err(done_err));

  // Five selectors give a 3-bit select field, so an out-of-range index is expressible.
  kinase_valve_sequencer #(.NUM_SEL(5)) u_dut5 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready5),
    .cmd_ctrl(cmd_ctrl), .cmd_sel(cmd_sel), .cmd_pump(cmd_pump),
    .cmd_cycles(cmd_cycles), .cmd_flush(cmd_flush), .abort(abort),
    .ctrl_a(ctrl_a5), .ctrl_s(ctrl_s5), .pump_a(pump_a5), .flush_ctrl(flush_ctrl5),
    .flush_pump(flush_pump5), .busy(busy5), .done(done5), .done_abort(done_abort5),
    .done_err(done_err5));

  typedef struct {
    int st;  // 0 idle, 1 settle, 2 run, 3 flush, 4 done
    logic [12:0] ca; logic [3:0] cs; logic [4:0] cs2; logic [8:0] pa;
    logic [12:0] fc; logic [2:0] fp; logic dn, da, de, de2;
  } ent_t;
  typedef struct { int lat; logic ab; } dexp_t;

  ent_t  q[$];
  ent_t  cur;
  dexp_t dq[$];
  int    acc_log[$];
  int    n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0, n_acc = 0;
  logic [12:0] m_ctrl;
  logic [2:0]  m_sel, m_pump;
  logic [15:0] m_cyc;
  logic        m_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic ent_t blank();
    ent_t e;
    e.st = 0; e.ca = '0; e.cs = '0; e.cs2 = '0; e.pa = '0; e.fc = '0; e.fp = '0;
    e.dn = 1'b0; e.da = 1'b0; e.de = 1'b0; e.de2 = 1'b0;
    return e;
  endfunction

  function automatic ent_t drive_ent(input int st, input int k);
    ent_t e = blank();
    int ph = (k / DIV) % PH;
    e.st  = st;
    e.ca  = m_ctrl;
    e.cs  = 4'b0001 << m_sel[1:0];
    e.cs2 = (m_sel < 3'd5) ? (5'b00001 << m_sel) : 5'b00000;
    if (st == 2)
      for (int i = 0; i < 3; i++) if (m_pump[i]) e.pa[i*PH + ph] = 1'b1;
    return e;
  endfunction

  task automatic push_tail(input logic fl, input logic ab);
    ent_t e;
    if (fl)
      for (int k = 0; k < F; k++) begin
        e = blank(); e.st = 3; e.fc = m_ctrl; e.fp = m_pump; q.push_back(e);
      end
    e = blank(); e.st = 4; e.dn = 1'b1; e.da = ab; e.de2 = (m_sel >= 3'd5);
    q.push_back(e);
  endtask

  task automatic gen_step();
    for (int k = 0; k < S; k++) q.push_back(drive_ent(1, k));
    for (int k = 0; k < int'(m_cyc); k++) q.push_back(drive_ent(2, k));
    push_tail(m_fl, 1'b0);
  endtask

  // Reference model + per-cycle comparison; inputs are stable at the edge (driven on negedge).
  always begin
    dexp_t d;
    @(posedge clk);
    cyc++;
    if (rst) q.delete();
    else if ((cur.st == 1 || cur.st == 2) && abort) begin
      q.delete();
      push_tail(1'b1, 1'b1);
    end else if (cur.st == 0 && cmd_valid) begin
      m_ctrl = cmd_ctrl; m_sel = cmd_sel; m_pump = cmd_pump; m_cyc = cmd_cycles; m_fl = cmd_flush;
      acc_cyc = cyc; acc_log.push_back(cyc); n_acc++;
      gen_step();
    end
    if (q.size() > 0) cur = q.pop_front();
    else              cur = blank();
    #1;
    chk("cmd_ready", cmd_ready, cur.st == 0);
    chk("busy", busy, cur.st != 0);
    chk("ctrl_a", ctrl_a, cur.ca);
    chk("ctrl_s", ctrl_s, cur.cs);
    chk("pump_a", pump_a, cur.pa);
    chk("flush_ctrl", flush_ctrl, cur.fc);
    chk("flush_pump", flush_pump, cur.fp);
    chk("done", done, cur.dn);
    chk("done_abort", done_abort, cur.da);
    chk("done_err", done_err, cur.de);
    chk("ctrl_s5", ctrl_s5, cur.cs2);
    chk("done_err5", done_err5, cur.de2);
    chk("misc5", {cmd_ready5, busy5, ctrl_a5, pump_a5, flush_ctrl5, flush_pump5, done5, done_abort5},
                 {cur.st == 0, cur.st != 0, cur.ca, cur.pa, cur.fc, cur.fp, cur.dn, cur.da});
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("done_unexpected", done, 1'b0);
      else begin
        d = dq.pop_front();
        chk("done_latency", cyc - acc_cyc, d.lat);
        chk("done_abort_sb", done_abort, d.ab);
      end
    end
  end

  task automatic exp_done(input int lat, input logic ab);
    dexp_t d; d.lat = lat; d.ab = ab; dq.push_back(d);
  endtask

  // Present a command for one edge, then scramble the fields to show they are not re-sampled.
  task automatic issue(input logic [12:0] c, input logic [2:0] s, input logic [2:0] p,
                       input logic [15:0] n, input logic fl);
    cmd_ctrl = c; cmd_sel = s; cmd_pump = p; cmd_cycles = n; cmd_flush = fl; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_ctrl = ~c; cmd_sel = s ^ 3'd1; cmd_pump = ~p; cmd_cycles = n + 16'd5; cmd_flush = ~fl;
  endtask

  task automatic wait_idle(input int lim);
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (cur.st == 0 && q.size() == 0) return;
    end
    chk("timeout_idle", cur.st, 0);
  endtask

  task automatic wait_acc(input int target, input int lim);
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (n_acc >= target) return;
    end
    chk("timeout_accept", n_acc, target);
  endtask

  initial begin
    int n0;
    cur = blank();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    exp_done(S + 24 + F, 1'b0);
    issue(13'h0A5, 3'd2, 3'b101, 16'd24, 1'b1);
    wait_idle(200);

    exp_done(S, 1'b0);
    issue(13'h1FFF, 3'd3, 3'b111, 16'd0, 1'b0);
    wait_idle(100);

    // Abort during RUN clock 5, then a second abort while flushing.
    exp_done(S + 6 + F, 1'b1);
    issue(13'h155, 3'd1, 3'b011, 16'd20, 1'b0);
    repeat (S + 5) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    wait_idle(100);

    // Selector 5: in range for neither instance's decode width in the same way.
    exp_done(S + 6 + F, 1'b0);
    issue(13'h0F0, 3'd5, 3'b010, 16'd6, 1'b1);
    wait_idle(100);

    exp_done(4 + F, 1'b1);
    issue(13'h00F, 3'd0, 3'b100, 16'd10, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    wait_idle(100);

    // Abort together with cmd_valid in IDLE is ignored.
    exp_done(S + 3, 1'b0);
    abort = 1'b1;
    issue(13'h0AA, 3'd2, 3'b001, 16'd3, 1'b0);
    abort = 1'b0;
    wait_idle(100);

    // Three commands with cmd_valid held high throughout.
    exp_done(S + 5, 1'b0);
    exp_done(S + 1 + F, 1'b0);
    exp_done(S + 7, 1'b0);
    n0 = n_acc;
    cmd_ctrl = 13'h001; cmd_sel = 3'd0; cmd_pump = 3'b001; cmd_cycles = 16'd5; cmd_flush = 1'b0;
    cmd_valid = 1'b1;
    wait_acc(n0 + 1, 100);
    cmd_ctrl = 13'h002; cmd_sel = 3'd1; cmd_pump = 3'b010; cmd_cycles = 16'd1; cmd_flush = 1'b1;
    wait_acc(n0 + 2, 100);
    cmd_ctrl = 13'h1000; cmd_sel = 3'd3; cmd_pump = 3'b100; cmd_cycles = 16'd7; cmd_flush = 1'b0;
    wait_acc(n0 + 3, 100);
    cmd_valid = 1'b0; cmd_ctrl = 13'h1555; cmd_cycles = 16'd99;
    wait_idle(100);
    if (acc_log.size() >= n0 + 3) begin
      chk("b2b_gap1", acc_log[n0+1] - acc_log[n0], S + 5 + 2);
      chk("b2b_gap2", acc_log[n0+2] - acc_log[n0+1], S + 1 + F + 2);
    end else chk("b2b_accepts", acc_log.size(), n0 + 3);

    // Reset in the middle of FLUSH: no done for this step.
    issue(13'h0FF, 3'd0, 3'b111, 16'd2, 1'b1);
    repeat (S + 2 + 5) @(negedge clk);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    exp_done(S + 1, 1'b0);
    issue(13'h1001, 3'd3, 3'b110, 16'd1, 1'b0);
    wait_idle(100);
    repeat (2) @(negedge clk);

    chk("sb_drained", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
